// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-memory request/response bus between the MEM stage and memory
interface mem_access_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data memory access controller with stall, timeout and MEM/WB register
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    startin,
  input  logic [1:0]              MEM_wb,
  input  logic                    MEM_mem_read,
  input  logic                    MEM_mem_write,
  input  logic [31:0]             MEM_alu_result,
  input  logic [31:0]             MEM_forward_b_mux_out,
  input  logic [4:0]              MEM_reg_dst_mux_out,
  mem_access_ctrl_if.master       dmem,
  output logic                    mem_stall,
  output logic [1:0]              WB_wb,
  output logic [31:0]             WB_read_data,
  output logic [31:0]             WB_alu_result,
  output logic [4:0]              WB_reg_dst_mux_out,
  output logic                    mem_err,
  output logic [31:0]             mem_err_addr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_cap;
  logic [1:0]  r_wb;
  logic [31:0] r_read_data;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;
  logic        r_err;
  logic [31:0] r_err_addr;

  logic w_access;
  logic w_aligned;
  logic w_issue;

  assign w_access  = MEM_mem_read | MEM_mem_write;
  assign w_aligned = (MEM_alu_result[1:0] == 2'b00);
  assign w_issue   = (r_state == IDLE) && w_access && w_aligned;

  // Stall must drop during reset so a frozen pipeline can never outlive a reset.
  assign mem_stall = !startin && ((r_state == BUSY) || w_issue);

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  assign WB_wb              = r_wb;
  assign WB_read_data       = r_read_data;
  assign WB_alu_result      = r_alu;
  assign WB_reg_dst_mux_out = r_rd;
  assign mem_err            = r_err;
  assign mem_err_addr       = r_err_addr;

  always_ff @(posedge clk) begin
    if (startin) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cap       <= '0;
      r_wb        <= '0;
      r_read_data <= '0;
      r_alu       <= '0;
      r_rd        <= '0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= MEM_mem_write;
            r_addr  <= MEM_alu_result;
            r_wdata <= MEM_forward_b_mux_out;
            r_cnt   <= '0;
            r_wb    <= '0;
            r_state <= BUSY;
          end else begin
            // Misaligned accesses retire as a bubble and only raise the error flag.
            r_wb        <= w_access ? 2'b00 : MEM_wb;
            r_read_data <= '0;
            r_alu       <= MEM_alu_result;
            r_rd        <= MEM_reg_dst_mux_out;
            if (w_access) begin
              r_err <= 1'b1;
              if (!r_err) r_err_addr <= MEM_alu_result;
            end
          end
        end
        BUSY: begin
          r_wb <= '0;
          if (dmem.dmem_ack) begin
            r_cap   <= r_we ? 32'h0 : dmem.dmem_rdata;
            r_req   <= 1'b0;
            r_state <= DONE;
          end else if (r_cnt == LAST_CNT) begin
            r_cap   <= '0;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            if (!r_err) r_err_addr <= r_addr;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_wb        <= MEM_wb;
          r_read_data <= r_cap;
          r_alu       <= MEM_alu_result;
          r_rd        <= MEM_reg_dst_mux_out;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum BUSY cycles allowed without dmem_ack.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 startin  in  1  reset; synchronous, active-high.
REQ-004 MEM_wb  in  2  writeback control from the EX/MEM register.
REQ-005 MEM_mem_read  in  1  load request.
REQ-006 MEM_mem_write  in  1  store request.
REQ-007 MEM_alu_result  in  32  effective address, or ALU result for non-memory ops.
REQ-008 MEM_forward_b_mux_out  in  32  store data.
REQ-009 MEM_reg_dst_mux_out  in  5  destination register number.
REQ-010 dmem_req  out  1  memory request, registered.
REQ-011 dmem_we  out  1  1 = write, 0 = read, registered.
REQ-012 dmem_addr  out  32  registered address.
REQ-013 dmem_wdata  out  32  registered store data.
REQ-014 dmem_ack  in  1  one-cycle completion pulse from memory.
REQ-015 dmem_rdata  in  32  read data, valid with dmem_ack.
REQ-016 mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-017 WB_wb  out  2  registered writeback control.
REQ-018 WB_read_data  out  32  registered load data.
REQ-019 WB_alu_result  out  32  registered ALU result.
REQ-020 WB_reg_dst_mux_out  out  5  registered destination register.
REQ-021 mem_err  out  1  sticky error flag.
REQ-022 mem_err_addr  out  32  address of the first error.

Function
REQ-023 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-024 An access SHALL be MEM_mem_read | MEM_mem_write; aligned means MEM_alu_result[1:0] == 0.
REQ-025 IDLE with an aligned access SHALL assert mem_stall, latch dmem_addr/dmem_wdata/dmem_we, set dmem_req = 1 at the edge, and go to BUSY.
REQ-026 With both read and write set, the access SHALL be a write (dmem_we = 1), with no error.
REQ-027 BUSY SHALL hold mem_stall = 1 and dmem_req/dmem_we/dmem_addr/dmem_wdata stable.
REQ-028 BUSY with dmem_ack SHALL capture dmem_rdata (reads) or 0 (writes), clear dmem_req at the edge, and go to DONE.
REQ-029 A cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-030 On the count reaching TIMEOUT_CYCLES-1 without ack, the block SHALL go to DONE with captured data 0, clear dmem_req, and set mem_err.
REQ-031 DONE SHALL deassert mem_stall for exactly one cycle and load the MEM/WB outputs with MEM_wb, captured data, MEM_alu_result and MEM_reg_dst_mux_out; next state IDLE.
REQ-032 DONE SHALL never start a new access, even though the same instruction is still presented.
REQ-033 While mem_stall = 1, the MEM/WB outputs SHALL load a bubble (WB_wb = 0; other fields unchanged).
REQ-034 IDLE with no access SHALL leave mem_stall = 0 and load the passthrough fields with WB_read_data = 0.
REQ-035 IDLE with a misaligned access SHALL issue no request and no stall, load the passthrough with WB_wb = 0, and set mem_err.
REQ-036 mem_err_addr SHALL capture the address only when mem_err is 0; mem_err SHALL clear only on reset.
REQ-037 dmem_ack SHALL be ignored in IDLE and DONE.
REQ-038 Minimum access latency SHALL be 2 stall cycles (IDLE issue plus BUSY with immediate ack), followed by DONE.

Reset
REQ-039 startin = 1 SHALL force IDLE, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0, WB_* = 0, mem_err = 0, mem_err_addr = 0, counter = 0, and mem_stall = 0 in that cycle, overriding any in-flight access.
REQ-040 After reset, the first access SHALL start only in a cycle where startin = 0.

Verification
REQ-041 Load, addr 0x100, ack in the 3rd BUSY cycle with rdata 0xDEADBEEF -> mem_stall high 4 cycles, then WB_read_data = 0xDEADBEEF and WB_wb = MEM_wb after DONE.
REQ-042 Store, addr 0x200, wdata 0x12345678, ack in the 1st BUSY cycle -> dmem_we = 1, stable fields, mem_stall high 2 cycles, WB_read_data = 0.
REQ-043 Load, addr 0x103 -> dmem_req stays 0, mem_stall = 0, WB_wb = 0, mem_err = 1, mem_err_addr = 0x103.
REQ-044 Load with no ack, TIMEOUT_CYCLES = 16 -> dmem_req high exactly 16 cycles, WB_read_data = 0, mem_err = 1.
REQ-045 startin asserted in the 2nd BUSY cycle, then an ack next cycle -> dmem_req = 0 after the edge, state IDLE, ack ignored, WB_* = 0.
REQ-046 Back-to-back loads 0x10 and 0x14, each acked immediately -> two separate requests, one DONE cycle between them, both WB results correct in order.
